// File: rtl/ex_pipeline_controller.sv
// Execute-stage sequencing controller: owns the NZCV status register,
// issues branch flushes and freezes the pipeline during SRAM accesses.
module ex_pipeline_controller #(
  parameter int unsigned LEN_STATUS   = 4,
  parameter int unsigned LEN_ADDRESS  = 32,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 63
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_valid,
  input  logic                   ex_is_branch,
  input  logic                   ex_s_bit,
  input  logic                   ex_mem_read,
  input  logic                   ex_mem_write,
  input  logic [LEN_STATUS-1:0]  alu_status_bits,
  input  logic [LEN_ADDRESS-1:0] branch_address,
  input  logic                   mem_ready,
  output logic [LEN_STATUS-1:0]  status_reg,
  output logic                   branch_taken,
  output logic [LEN_ADDRESS-1:0] branch_target,
  output logic                   flush,
  output logic                   freeze,
  output logic                   mem_req,
  output logic                   mem_error,
  output logic [1:0]             state
);

  localparam int unsigned FLUSH_W = 4;
  localparam int unsigned TIMER_W = 8;

  // Counter reload / terminal values; FLUSH_CYCLES and MEM_TIMEOUT are >= 1.
  localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  state_e                 state_q;
  state_e                 state_d;
  logic [FLUSH_W-1:0]     flush_cnt_q;
  logic [FLUSH_W-1:0]     flush_cnt_d;
  logic [TIMER_W-1:0]     timer_q;
  logic [TIMER_W-1:0]     timer_d;
  logic [LEN_STATUS-1:0]  status_d;
  logic                   branch_taken_d;
  logic [LEN_ADDRESS-1:0] branch_target_d;
  logic                   flush_d;
  logic                   mem_req_d;
  logic                   mem_error_d;
  logic                   accept;
  logic                   is_mem_op;

  // Only instructions seen while running are evaluated.
  assign accept    = ex_valid & (state_q == ST_RUN);
  assign is_mem_op = ex_mem_read | ex_mem_write;

  // Freeze must drop in the very cycle the SRAM reports completion.
  assign freeze = (state_q == ST_MEM_WAIT) & ~mem_ready;

  assign state = state_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-value logic for every registered output and counter.
  always_comb begin
    state_d         = state_q;
    flush_cnt_d     = flush_cnt_q;
    timer_d         = timer_q;
    status_d        = status_reg;
    branch_taken_d  = 1'b0;
    branch_target_d = branch_target;
    flush_d         = flush;
    mem_req_d       = mem_req;
    mem_error_d     = mem_error;

    // Flags update only on the accept cycle, never while waiting.
    if (accept && ex_s_bit) begin
      status_d = alu_status_bits;
    end

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (ex_is_branch) begin
            // Branch wins over any memory bits on the same instruction.
            branch_target_d = branch_address;
            branch_taken_d  = 1'b1;
            flush_d         = 1'b1;
            flush_cnt_d     = FLUSH_LOAD;
            state_d         = ST_FLUSH;
          end else if (is_mem_op) begin
            mem_req_d = 1'b1;
            timer_d   = '0;
            state_d   = ST_MEM_WAIT;
          end
        end
      end

      ST_MEM_WAIT: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = ST_RUN;
        end else if (timer_q == TIMER_LAST) begin
          // Abandon the access; error stays set until reset.
          mem_error_d = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = ST_RUN;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          flush_d = 1'b0;
          state_d = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
        end
      end

      default: begin
        flush_d   = 1'b0;
        mem_req_d = 1'b0;
        state_d   = ST_RUN;
      end
    endcase
  end

  // Registered outputs and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt_q   <= '0;
      timer_q       <= '0;
      status_reg    <= '0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
      flush         <= 1'b0;
      mem_req       <= 1'b0;
      mem_error     <= 1'b0;
    end else begin
      flush_cnt_q   <= flush_cnt_d;
      timer_q       <= timer_d;
      status_reg    <= status_d;
      branch_taken  <= branch_taken_d;
      branch_target <= branch_target_d;
      flush         <= flush_d;
      mem_req       <= mem_req_d;
      mem_error     <= mem_error_d;
    end
  end

endmodule

// File: tb/tb_ex_pipeline_controller.sv
// Bench for ex_pipeline_controller: directed scenarios followed by random
// traffic, all checked against a cycle-count based reference model.
module tb_ex_pipeline_controller;

  localparam int unsigned LS = 4;
  localparam int unsigned LA = 32;
  localparam int unsigned FC = 2;
  localparam int unsigned MT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid;
  logic          ex_is_branch;
  logic          ex_s_bit;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic [LS-1:0] alu_status_bits;
  logic [LA-1:0] branch_address;
  logic          mem_ready;
  logic [LS-1:0] status_reg;
  logic          branch_taken;
  logic [LA-1:0] branch_target;
  logic          flush;
  logic          freeze;
  logic          mem_req;
  logic          mem_error;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  // Reference model: flags, pending flush cycles, outstanding access age.
  logic [LS-1:0] m_flags;
  logic          m_taken;
  logic [LA-1:0] m_target;
  int            m_flush_left;
  bit            m_busy;
  int            m_elapsed;
  bit            m_err;

  always #5 clk = ~clk;

  ex_pipeline_controller #(
    .LEN_STATUS  (LS),
    .LEN_ADDRESS (LA),
    .FLUSH_CYCLES(FC),
    .MEM_TIMEOUT (MT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_s_bit       (ex_s_bit),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .alu_status_bits(alu_status_bits),
    .branch_address (branch_address),
    .mem_ready      (mem_ready),
    .status_reg     (status_reg),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .flush          (flush),
    .freeze         (freeze),
    .mem_req        (mem_req),
    .mem_error      (mem_error),
    .state          (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_flags      = '0;
    m_taken      = 1'b0;
    m_target     = '0;
    m_flush_left = 0;
    m_busy       = 1'b0;
    m_elapsed    = 0;
    m_err        = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs held across it.
  task automatic model_edge();
    bit run;
    if (rst) begin
      model_reset();
      return;
    end
    run = !m_busy && (m_flush_left == 0);
    if (run && ex_valid && ex_s_bit) m_flags = alu_status_bits;
    if (m_flush_left > 0) begin
      m_flush_left--;
      m_taken = 1'b0;
    end else if (m_busy) begin
      if (mem_ready) begin
        m_busy = 1'b0;
      end else begin
        m_elapsed++;
        if (m_elapsed == int'(MT)) begin
          m_busy = 1'b0;
          m_err  = 1'b1;
        end
      end
    end else if (ex_valid) begin
      if (ex_is_branch) begin
        m_target     = branch_address;
        m_taken      = 1'b1;
        m_flush_left = int'(FC);
      end else if (ex_mem_read || ex_mem_write) begin
        m_busy    = 1'b1;
        m_elapsed = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("status_reg", 32'(status_reg), 32'(m_flags));
    chk("branch_taken", 32'(branch_taken), 32'(m_taken));
    chk("branch_target", branch_target, m_target);
    chk("flush", 32'(flush), (m_flush_left > 0) ? 32'd1 : 32'd0);
    chk("freeze", 32'(freeze), (m_busy && !mem_ready) ? 32'd1 : 32'd0);
    chk("mem_req", 32'(mem_req), 32'(m_busy));
    chk("mem_error", 32'(mem_error), 32'(m_err));
    chk("state", 32'(state), m_busy ? 32'd1 : ((m_flush_left > 0) ? 32'd2 : 32'd0));
  endtask

  // Check the current cycle, then cross one rising edge; returns at edge+1.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    ex_valid        = 1'b0;
    ex_is_branch    = 1'b0;
    ex_s_bit        = 1'b0;
    ex_mem_read     = 1'b0;
    ex_mem_write    = 1'b0;
    alu_status_bits = '0;
    branch_address  = '0;
    mem_ready       = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_status", 32'(status_reg), 32'd0);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_freeze", 32'(freeze), 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_flush", 32'(flush), 32'd0);
    rst = 1'b0;

    // Flags load on a flag-setting instruction, hold otherwise.
    ex_valid = 1'b1; ex_s_bit = 1'b1; alu_status_bits = 4'b1001;
    step();
    chk("flags_set", 32'(status_reg), 32'h9);
    ex_s_bit = 1'b0; alu_status_bits = 4'b0110;
    step();
    chk("flags_hold", 32'(status_reg), 32'h9);
    idle();

    // Taken branch: one-cycle branch_taken, flush for FC cycles, second branch ignored.
    ex_valid = 1'b1; ex_is_branch = 1'b1; branch_address = 32'h0000_0040;
    step();
    chk("br_taken", 32'(branch_taken), 32'd1);
    chk("br_target", branch_target, 32'h40);
    chk("br_flush1", 32'(flush), 32'd1);
    chk("br_state_flush", 32'(state), 32'd2);
    branch_address = 32'h0000_0080;
    step();
    idle();
    chk("br_taken_drop", 32'(branch_taken), 32'd0);
    chk("br_flush2", 32'(flush), 32'd1);
    chk("br_target_kept", branch_target, 32'h40);
    step();
    chk("br_flush_end", 32'(flush), 32'd0);
    chk("br_state_run", 32'(state), 32'd0);

    // Load completing after four frozen cycles.
    ex_valid = 1'b1; ex_mem_read = 1'b1;
    step();
    idle();
    chk("ld_mem_req", 32'(mem_req), 32'd1);
    chk("ld_state", 32'(state), 32'd1);
    for (int i = 0; i < 4; i++) begin
      #1 chk("ld_freeze", 32'(freeze), 32'd1);
      step();
    end
    mem_ready = 1'b1;
    #1 chk("ld_freeze_ready", 32'(freeze), 32'd0);
    step();
    mem_ready = 1'b0;
    chk("ld_mem_req_drop", 32'(mem_req), 32'd0);
    chk("ld_state_run", 32'(state), 32'd0);
    chk("ld_no_error", 32'(mem_error), 32'd0);

    // Branch and store on the same instruction: branch wins.
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_mem_write = 1'b1; branch_address = 32'h0000_1234;
    step();
    idle();
    chk("bw_state", 32'(state), 32'd2);
    chk("bw_mem_req", 32'(mem_req), 32'd0);
    step();
    step();
    chk("bw_state_run", 32'(state), 32'd0);

    // Timeout: never ready, freeze for MT cycles then sticky error.
    ex_valid = 1'b1; ex_mem_read = 1'b1;
    step();
    idle();
    for (int i = 0; i < int'(MT); i++) begin
      #1 chk("to_freeze", 32'(freeze), 32'd1);
      step();
    end
    chk("to_error", 32'(mem_error), 32'd1);
    chk("to_mem_req", 32'(mem_req), 32'd0);
    chk("to_state", 32'(state), 32'd0);
    #1 chk("to_freeze_drop", 32'(freeze), 32'd0);

    // Second access after timeout, then a back-to-back access.
    ex_valid = 1'b1; ex_mem_write = 1'b1;
    step();
    idle();
    chk("st_mem_req", 32'(mem_req), 32'd1);
    step();
    mem_ready = 1'b1;
    #1 chk("st_freeze_ready", 32'(freeze), 32'd0);
    step();
    mem_ready = 1'b0;
    chk("st_done", 32'(mem_req), 32'd0);
    chk("st_error_sticky", 32'(mem_error), 32'd1);
    ex_valid = 1'b1; ex_mem_read = 1'b1;
    step();
    idle();
    chk("b2b_state", 32'(state), 32'd1);
    chk("b2b_mem_req", 32'(mem_req), 32'd1);
    step();

    // Asynchronous reset between edges while waiting on memory.
    #3 rst = 1'b1;
    #1;
    chk("arst_freeze", 32'(freeze), 32'd0);
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_status", 32'(status_reg), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_error", 32'(mem_error), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      ex_valid        = ($urandom_range(0, 9) < 7);
      ex_is_branch    = ($urandom_range(0, 4) == 0);
      ex_s_bit        = ($urandom_range(0, 1) == 1);
      ex_mem_read     = ($urandom_range(0, 3) == 0);
      ex_mem_write    = ($urandom_range(0, 3) == 0);
      alu_status_bits = LS'($urandom);
      branch_address  = $urandom;
      mem_ready       = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_pipeline_controller.md
Name: ex_pipeline_controller

Overview:
Sequencing controller for the execute stage of the 5-stage ARM-subset pipeline. Owns the NZCV status register that feeds the EX stage's status_reg_in. Issues branch flushes and freezes the pipeline while a load/store waits on the SRAM controller. Sits beside the EX stage and drives the enable/flush inputs of every pipeline register.

Parameters:
LEN_STATUS, 4, status register width (NZCV, bit 3 = N ... bit 0 = V)
LEN_ADDRESS, 32, instruction address width
FLUSH_CYCLES, 1, number of cycles flush stays high after a taken branch (1..15)
MEM_TIMEOUT, 63, maximum freeze cycles before a memory access is abandoned (1..255)

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-high reset
ex_valid  in  1  EX stage holds a real (non-bubble) instruction this cycle
ex_is_branch  in  1  instruction in EX is a branch whose condition passed
ex_s_bit  in  1  instruction in EX updates flags
ex_mem_read  in  1  instruction in EX is a load
ex_mem_write  in  1  instruction in EX is a store
alu_status_bits  in  LEN_STATUS  NZCV produced by the EX-stage ALU
branch_address  in  LEN_ADDRESS  branch target computed by the EX stage
mem_ready  in  1  SRAM controller completed the access (1-cycle pulse)
status_reg  out  LEN_STATUS  current flags, fed to EX status_reg_in
branch_taken  out  1  IF must load branch_target this cycle
branch_target  out  LEN_ADDRESS  registered copy of branch_address
flush  out  1  clear IF/ID and ID/EX registers
freeze  out  1  hold all pipeline registers and PC
mem_req  out  1  access request to the SRAM controller
mem_error  out  1  sticky: an access hit MEM_TIMEOUT
state  out  2  FSM state, for debug (RUN=0, MEM_WAIT=1, FLUSH=2)

Behaviour:
- Reset (asynchronous, immediate): state=RUN. status_reg=0, branch_taken=0, branch_target=0, flush=0, mem_req=0, mem_error=0, all counters=0. freeze=0.
- accept = ex_valid & (state==RUN). Instructions in MEM_WAIT or FLUSH are not re-evaluated.
- Flags: on a rising edge with accept & ex_s_bit, status_reg <= alu_status_bits. Otherwise it holds. A flag-setting load/store updates the flags on its accept cycle only, never again while waiting.
- RUN, accept & ex_is_branch: this has priority over memory bits, which are ignored on the same cycle.
  - Next edge: branch_target <= branch_address, branch_taken=1 for exactly one cycle, flush=1, counter loads FLUSH_CYCLES-1, state=FLUSH.
- FLUSH: flush=1 and branch_taken=0 after the first cycle. The counter decrements each cycle. At 0, flush deasserts on the next edge and state=RUN. Total flush high time = FLUSH_CYCLES cycles. A branch in EX during FLUSH is ignored.
- RUN, accept & (ex_mem_read | ex_mem_write) & !ex_is_branch: next edge sets mem_req=1, timer=0, state=MEM_WAIT.
- MEM_WAIT:
  - freeze = 1 combinationally while state==MEM_WAIT & !mem_ready. freeze drops in the same cycle mem_ready is seen.
  - mem_req stays high until mem_ready.
  - On mem_ready: next edge sets mem_req=0, state=RUN.
  - Otherwise the timer increments. When timer==MEM_TIMEOUT-1 and still !mem_ready, the next edge sets mem_error=1, mem_req=0, state=RUN, and freeze deasserts.
- mem_ready outside MEM_WAIT is ignored.
- mem_error clears only on rst.
- freeze is 0 in RUN and FLUSH. flush and freeze are never both 1.
- Back-to-back: a memory op accepted on the cycle after returning to RUN starts a new MEM_WAIT with no bubble.
- Reset mid-MEM_WAIT or mid-FLUSH aborts immediately to reset values. The SRAM controller must tolerate mem_req dropping.
- All outputs except freeze are registered.

Test Plan:
- Reset then ex_valid=1, ex_s_bit=1, alu_status_bits=4'b1001 -> status_reg=4'b1001 after one edge. With ex_s_bit=0 and bits=4'b0110 on the next cycle, status_reg stays 4'b1001.
- Branch with branch_address=32'h0000_0040, FLUSH_CYCLES=2 -> branch_taken high 1 cycle, branch_target=32'h40, flush high exactly 2 cycles, state returns to RUN.
- Load accepted, mem_ready pulsed 4 cycles after mem_req rises -> freeze high 4 cycles, low in the mem_ready cycle, mem_req low the next cycle, mem_error=0.
- ex_is_branch=1 with ex_mem_write=1 together -> FLUSH entered, mem_req stays 0.
- MEM_TIMEOUT=8, mem_ready never asserted -> freeze high 8 cycles, then mem_error=1 (sticky), mem_req=0, state=RUN. A second load still works.
- rst asserted asynchronously between edges mid-MEM_WAIT -> freeze, mem_req and status_reg go to 0 immediately, state=RUN.
